// File: rtl/w_unpack_stream_if.sv
// Handshake bundle for the weight unpacker: packed words in, lane-replicated beats out.
// slave is the unpacker's view; master is the producer/consumer side.
interface w_unpack_stream_if #(
    parameter int BYTES  = 4,
    parameter int WORD_W = 8 * BYTES,
    parameter int BW     = ($clog2(BYTES) < 1) ? 1 : $clog2(BYTES)
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic [2:0]        mode;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [BW-1:0]     out_beat;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, in_last, mode, out_ready,
        output in_ready, out_valid, out_data, out_beat, out_last
    );

    modport master (
        output in_valid, in_data, in_last, mode, out_ready,
        input  in_ready, out_valid, out_data, out_beat, out_last
    );
endinterface

// File: rtl/w_unpack_stream.sv
// One-entry weight-word buffer that emits lane-replicated beats per 2b/4b/8b mode,
// with zero-bubble word handover, flush, tile-last tagging and sticky illegal-mode flag.
//
// state | meaning
// EMPTY | no buffered word; in_ready=1 unless flushing
// HOLD  | buffered word being emitted, ptr_q selects the beat
module w_unpack_stream #(
    parameter int BYTES  = 4,
    parameter int WORD_W = 8 * BYTES
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              flush,
    output logic              err_mode,
    w_unpack_stream_if.slave  bus
);
    localparam int LB = $clog2(BYTES);
    localparam int PW = (LB < 1) ? 1 : LB;

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t            state_q,    state_d;
    logic [WORD_W-1:0] buf_data_q, buf_data_d;
    logic [2:0]        buf_mode_q, buf_mode_d;
    logic              buf_last_q, buf_last_d;
    logic [PW-1:0]     ptr_q,      ptr_d;
    logic              err_mode_q, err_mode_d;

    logic [1:0]        lg_g;
    logic              mode_ok;
    logic [PW-1:0]     last_ptr;
    logic [PW-1:0]     src_idx;
    logic [WORD_W-1:0] lanes;
    logic              beat_fire;
    logic              final_fire;
    logic              accept;
    logic              in_mode_ok;

    // log2 of distinct bytes per beat for the buffered word; illegal modes emit a single zero beat
    always_comb begin
        lg_g    = 2'd0;
        mode_ok = 1'b1;
        case (buf_mode_q)
            3'b001:  lg_g = 2'd2;
            3'b010:  lg_g = 2'd1;
            3'b100:  lg_g = 2'd0;
            default: mode_ok = 1'b0;
        endcase
        last_ptr = mode_ok ? PW'((BYTES >> lg_g) - 1) : '0;
    end

    // lane i carries byte (ptr*G + i/NB)
    always_comb begin
        lanes   = '0;
        src_idx = '0;
        for (int i = 0; i < BYTES; i++) begin
            src_idx = PW'((int'(ptr_q) << lg_g) + (i >> (LB - int'(lg_g))));
            lanes[8*i +: 8] = buf_data_q[8*int'(src_idx) +: 8];
        end
    end

    always_comb begin
        bus.out_valid = (state_q == HOLD);
        bus.out_data  = (state_q == HOLD && mode_ok) ? lanes : '0;
        bus.out_beat  = ptr_q;
        bus.out_last  = (state_q == HOLD) && buf_last_q && (ptr_q == last_ptr);
        err_mode      = err_mode_q;
    end

    always_comb begin
        in_mode_ok = (bus.mode == 3'b001) || (bus.mode == 3'b010) || (bus.mode == 3'b100);
        beat_fire  = (state_q == HOLD) && bus.out_ready;
        final_fire = beat_fire && (ptr_q == last_ptr);
        bus.in_ready = !flush && ((state_q == EMPTY) || final_fire);
        accept     = bus.in_valid && bus.in_ready;

        state_d    = state_q;
        buf_data_d = buf_data_q;
        buf_mode_d = buf_mode_q;
        buf_last_d = buf_last_q;
        ptr_d      = ptr_q;
        err_mode_d = err_mode_q;

        if (flush) begin
            state_d = EMPTY;
            ptr_d   = '0;
        end else begin
            if (final_fire) begin
                state_d = EMPTY;
                ptr_d   = '0;
            end else if (beat_fire) begin
                ptr_d = ptr_q + PW'(1);
            end
            if (accept) begin
                state_d    = HOLD;
                buf_data_d = bus.in_data;
                buf_mode_d = bus.mode;
                buf_last_d = bus.in_last;
                ptr_d      = '0;
                if (!in_mode_ok) err_mode_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q    <= EMPTY;
            buf_data_q <= '0;
            buf_mode_q <= '0;
            buf_last_q <= 1'b0;
            ptr_q      <= '0;
            err_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_data_q <= buf_data_d;
            buf_mode_q <= buf_mode_d;
            buf_last_q <= buf_last_d;
            ptr_q      <= ptr_d;
            err_mode_q <= err_mode_d;
        end
    end
endmodule

// File: tb/tb_w_unpack_stream.sv
// Bench for w_unpack_stream (BYTES=4): directed scenarios then random traffic,
// compared each cycle against a queue-of-beats reference model.
module tb_w_unpack_stream;
    logic clk = 1'b0;
    logic nRST;
    logic flush;
    logic err_mode;

    w_unpack_stream_if #(.BYTES(4)) bus ();

    w_unpack_stream #(.BYTES(4)) dut (
        .clk      (clk),
        .nRST     (nRST),
        .flush    (flush),
        .err_mode (err_mode),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  beat;
        logic        last;
    } beat_t;

    beat_t q[$];
    logic  m_err;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_onehot(input logic [2:0] m);
        return (m == 3'b001) || (m == 3'b010) || (m == 3'b100);
    endfunction

    // Expand one word into its beats: G bytes per beat, each repeated 4/G times
    function automatic void push_word(input logic [31:0] d, input logic [2:0] m, input logic l);
        int g;
        int nb;
        logic [31:0] w;
        case (m)
            3'b001:  g = 4;
            3'b010:  g = 2;
            3'b100:  g = 1;
            default: g = 0;
        endcase
        if (g == 0) begin
            q.push_back('{32'h0, 2'd0, l});
        end else begin
            nb = 4 / g;
            for (int k = 0; k < nb; k++) begin
                w = '0;
                for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(k*g + i/nb) +: 8];
                q.push_back('{w, 2'(k), l && (k == nb - 1)});
            end
        end
    endfunction

    task automatic cycle(input logic v, input logic [31:0] d, input logic [2:0] m, input logic l,
                         input logic ordy, input logic fl, input logic rst_n);
        logic        e_valid;
        logic        e_rdy;
        logic [31:0] e_data;
        logic [1:0]  e_beat;
        logic        e_last;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.mode      = m;
        bus.in_last   = l;
        bus.out_ready = ordy;
        flush         = fl;
        nRST          = rst_n;
        #1;
        e_valid = (q.size() > 0);
        e_data  = e_valid ? q[0].data : 32'h0;
        e_beat  = e_valid ? q[0].beat : 2'd0;
        e_last  = e_valid ? q[0].last : 1'b0;
        e_rdy   = !fl && (!e_valid || (q.size() == 1 && ordy));
        chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
        chk("out_data",  bus.out_data,       e_data);
        chk("out_beat",  32'(bus.out_beat),  32'(e_beat));
        chk("out_last",  32'(bus.out_last),  32'(e_last));
        chk("in_ready",  32'(bus.in_ready),  32'(e_rdy));
        chk("err_mode",  32'(err_mode),      32'(m_err));
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_err = 1'b0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (e_valid && ordy) void'(q.pop_front());
            if (v && e_rdy) begin
                push_word(d, m, l);
                if (!is_onehot(m)) m_err = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic [2:0] rm;
        int         r;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.mode = 3'b100; bus.in_last = 1'b0;
        bus.out_ready = 1'b0; flush = 1'b0; nRST = 1'b0; m_err = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state then idle
        idle(2);

        // 8b word, four beats, in_ready only on the last one
        cycle(1'b1, 32'hDDCCBBAA, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(5);

        // Reset in the middle of an 8b word at beat 2
        cycle(1'b1, 32'h12345678, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // 4b word with last, then 2b word back-to-back
        cycle(1'b1, 32'h44332211, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h88776655, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h88776655, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);

        // 8b word with out_ready toggling 1,0,0,1 while the next word waits
        cycle(1'b1, 32'hA4A3A2A1, 3'b100, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++)
            cycle(1'b1, 32'hB4B3B2B1, 3'b010, 1'b0, (i % 3) != 1 && (i % 3) != 2 ? 1'b1 : 1'b0, 1'b0, 1'b1);
        idle(4);

        // Illegal mode: one zero beat, sticky error across legal words
        cycle(1'b1, 32'hFFFFFFFF, 3'b011, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h0F0E0D0C, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h0F0E0D0C, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(3);

        // Flush during 4b beat 0 with a word offered
        cycle(1'b1, 32'h55443322, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h99887766, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 32'h99887766, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(3);

        // Reset clears the sticky error
        cycle(1'b0, 32'h0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 15));
            if (r < 5)       rm = 3'b001;
            else if (r < 10) rm = 3'b010;
            else if (r < 15) rm = 3'b100;
            else             rm = 3'($urandom);
            cycle(($urandom % 4) != 0, $urandom, rm, 1'($urandom), ($urandom % 4) != 0,
                  ($urandom % 32) == 0, ($urandom % 128) != 0);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/w_unpack_stream.md
Name: w_unpack_stream

Overview:
- Parametrised successor to the fixed 32-bit weight mux that feeds the BitFusion PE array.
- Accepts packed weight words over a valid/ready handshake and holds each word in a one-entry buffer.
- Emits one or more lane-replicated beats per word, according to the per-word weight bitwidth mode.
- Adds input/output backpressure, full-throughput back-to-back operation, tile-last propagation, flush, and illegal-mode detection.

Parameters:
- BYTES, 4: bytes per word (lanes). Must be a power of two, at least 4.
- WORD_W, 8*BYTES: word width in bits. Derived; must not be overridden independently.

Ports:
- clk, in, 1: clock; all state updates on rising edge.
- nRST, in, 1: synchronous active-low reset.
- mode, in, 3: weight bitwidth, one-hot. 001 = 2b, 010 = 4b, 100 = 8b. Sampled with each accepted word.
- flush, in, 1: synchronous discard of the buffered word.
- in_valid, in, 1: input word valid.
- in_ready, out, 1: block can accept a word this cycle.
- in_data, in, WORD_W: packed weight word.
- in_last, in, 1: word is the last of a tile.
- out_valid, out, 1: beat valid.
- out_ready, in, 1: consumer accepts beat.
- out_data, out, WORD_W: replicated beat; lane i = bits [8i+7:8i].
- out_beat, out, clog2(BYTES) (min 1): index of the current beat within the word.
- out_last, out, 1: final beat of a word that was accepted with in_last=1.
- err_mode, out, 1: sticky; set when a word is accepted with non-one-hot mode.

Behaviour:
- Group size G (distinct bytes per beat): 2b mode G = min(4, BYTES); 4b mode G = 2; 8b mode G = 1.
- Beats per word NB = BYTES/G. With BYTES=4: 2b → 1 beat, 4b → 2 beats, 8b → 4 beats.
- Beat k: out_data lane i = in_data byte (k*G + i/(BYTES/G)).
  - BYTES=4, 4b mode, beat 0 = {b1,b1,b0,b0} (MSB→LSB).
  - BYTES=4, 8b mode, beat k = {bk,bk,bk,bk}.
- State: buf_valid, buf_data, buf_mode, buf_last, beat ptr, err_mode.
  - Two states: EMPTY (buf_valid=0) and HOLD (buf_valid=1).
- Accept: in_valid && in_ready.
  - Latch in_data, mode, in_last; ptr ← 0; go to HOLD.
- in_ready = !buf_valid || (out_valid && out_ready && ptr == NB-1). This allows a 0-bubble handover between words.
- Output: out_valid = buf_valid. out_data, out_beat, out_last are combinational from the buffer.
  - Latency: word accepted at edge N gives beat 0 valid in the cycle after edge N.
  - When out_valid=0, out_data = 0 and out_last = 0.
- Beat consume: out_valid && out_ready.
  - ptr < NB-1: ptr increments.
  - ptr == NB-1: ptr ← 0. If an accept occurs in the same cycle, stay in HOLD with the new word; otherwise buf_valid ← 0.
- While out_ready=0: out_data, out_beat, out_last stay stable; ptr holds.
- mode changes while in HOLD do not affect the buffered word (buf_mode is used).
- out_last = buf_last && (ptr == NB-1).
- Illegal mode (not one-hot, including 000):
  - The word is accepted.
  - It produces exactly 1 beat with out_data = 0 and out_last = buf_last.
  - err_mode ← 1, cleared only by reset.
- flush = 1: buf_valid ← 0, ptr ← 0, in_ready forced to 0 that cycle (no accept). err_mode is unaffected.
  - flush has priority over beat consume and accept.
- Reset (nRST=0 at an edge, including mid-word): buf_valid, ptr, buf_data, buf_mode, buf_last, err_mode ← 0.
  - Outputs after reset: out_valid=0, out_data=0, out_beat=0, out_last=0, err_mode=0, in_ready=1.
- Throughput: with out_ready tied to 1, one beat per cycle continuously; a new word is accepted on each word's final beat.

Test Plan:
- Reset then idle → in_ready=1, out_valid=0, out_data=0, err_mode=0. Assert nRST=0 mid 8b word at beat 2 → next cycle out_valid=0, ptr=0.
- mode=100, in_data=0xDDCCBBAA, out_ready=1 → 4 beats 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC, 0xDDDDDDDD, out_beat 0..3; in_ready high only on beat 3.
- mode=010, 0x44332211 with in_last=1, then mode=001, 0x88776655 back-to-back → 0x22221111, 0x44443333 (out_last=1), then 0x88776655 on the next cycle with no bubble.
- 8b word with out_ready toggling 1,0,0,1,… → each beat held stable while stalled; no beat lost or duplicated; in_ready stays 0 until the final beat is consumed.
- mode=011, in_data=0xFFFFFFFF → one beat 0x00000000; err_mode=1 and stays 1 across further legal words until reset.
- flush=1 during 4b beat 0 with in_valid=1 → no accept that cycle; next cycle out_valid=0, in_ready=1; the following word starts at beat 0.
